// File: rtl/fetch_stage.sv
// RV32 instruction-fetch stage with IF/ID register. One outstanding imem request;
// absorbs memory latency, decode stalls/flushes and execute-stage redirects.
module fetch_stage #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [31:0]      NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {REQ, RESP, HOLD} state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pcf, pcf_n, req_pc, req_pc_n, hold_pc, target;
  logic [31:0]     hold_instr;
  logic            kill, kill_n, hold_we, ld_mem, ld_hold, advance;

  assign target  = PCTargetE & ~XLEN'(3);
  assign advance = !StallD && !FlushD;

  // Request is suppressed while reset is held so memory never sees a stale PC.
  assign imem_req  = (state == REQ) && !reset;
  assign imem_addr = pcf;

  always_comb begin
    state_n  = state;
    pcf_n    = pcf;
    req_pc_n = req_pc;
    kill_n   = kill;
    hold_we  = 1'b0;
    ld_mem   = 1'b0;
    ld_hold  = 1'b0;
    case (state)
      REQ: begin
        if (imem_gnt) begin
          state_n  = RESP;
          req_pc_n = pcf;
          kill_n   = PCSrcE;
        end
      end
      RESP: begin
        if (imem_rvalid) begin
          state_n = REQ;
          kill_n  = 1'b0;
          // Killed or redirected responses are dropped; PCF already points at the target.
          if (!kill && !PCSrcE) begin
            pcf_n = req_pc + XLEN'(4);
            if (advance) ld_mem = 1'b1;
            else begin
              hold_we = 1'b1;
              state_n = HOLD;
            end
          end
        end else if (PCSrcE) begin
          kill_n = 1'b1;
        end
      end
      HOLD: begin
        if (PCSrcE) state_n = REQ;
        else if (advance) begin
          ld_hold = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = REQ;
    endcase
    if (PCSrcE) pcf_n = target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REQ;
      pcf    <= RESET_PC;
      req_pc <= '0;
      kill   <= 1'b0;
    end else begin
      state  <= state_n;
      pcf    <= pcf_n;
      req_pc <= req_pc_n;
      kill   <= kill_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_instr <= NOP;
      hold_pc    <= '0;
    end else if (hold_we) begin
      hold_instr <= imem_rdata;
      hold_pc    <= req_pc;
    end
  end

  // Redirect and flush share the bubble path; stall simply holds.
  always_ff @(posedge clk) begin
    if (reset || PCSrcE || FlushD) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (ld_mem) begin
      InstrD   <= imem_rdata;
      PCD      <= req_pc;
      PCPlus4D <= req_pc + XLEN'(4);
      ValidD   <= 1'b1;
    end else if (ld_hold) begin
      InstrD   <= hold_instr;
      PCD      <= hold_pc;
      PCPlus4D <= hold_pc + XLEN'(4);
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected grant addresses and IF/ID loads are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, imem_gnt, imem_rvalid, StallD, FlushD, PCSrcE;
  logic [31:0] imem_rdata, PCTargetE;
  logic        imem_req, ValidD;
  logic [31:0] imem_addr, InstrD, PCD, PCPlus4D;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ifid_t;

  ifid_t       exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, return just after the capturing edge.
  task automatic step(input logic g, input logic rv, input logic [31:0] d,
                      input logic st, input logic fl, input logic ps, input logic [31:0] tg);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = d;
    StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic grant(input logic [31:0] a);
    addr_q.push_back(a);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resp(input logic [31:0] d, input logic [31:0] pc);
    exp_q.push_back('{instr: d, pc: pc, pc4: pc + 32'd4});
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: a new IF/ID entry is a valid word differing from what was shown before.
  initial begin
    logic        pv;
    logic [31:0] ppc, pin;
    ifid_t       e;
    pv = 1'b0; ppc = '0; pin = '0;
    forever begin
      @(negedge clk);
      if (!reset && imem_req && imem_gnt) begin
        if (addr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL grant_unexpected: got addr %h want no grant", imem_addr);
        end else chk("grant_addr", imem_addr, addr_q.pop_front());
      end
      if (!reset && ValidD && (!pv || PCD !== ppc || InstrD !== pin)) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ifid_unexpected: got %h@%h want no load", InstrD, PCD);
        end else begin
          e = exp_q.pop_front();
          chk("InstrD", InstrD, e.instr);
          chk("PCD", PCD, e.pc);
          chk("PCPlus4D", PCPlus4D, e.pc4);
        end
      end
      pv = ValidD; ppc = PCD; pin = InstrD;
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    reset = 1'b1;
    idle(); idle();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_InstrD", InstrD, 32'h13);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_ValidD", {31'b0, ValidD}, 32'd0);
    reset = 1'b0; #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // Back-to-back single-cycle memory
    grant(32'h0); resp(32'h00500093, 32'h0);
    grant(32'h4); resp(32'h00a00113, 32'h4);

    // Grant delayed 3, rvalid delayed 2
    repeat (3) begin
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h8);
      idle();
    end
    grant(32'h8);
    repeat (2) begin
      chk("resp_noreq", {31'b0, imem_req}, 32'd0);
      idle();
    end
    resp(32'h00308193, 32'h8);

    // StallD for 4 cycles spanning the response -> HOLD
    addr_q.push_back(32'hC);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    exp_q.push_back('{instr: 32'h00400213, pc: 32'hC, pc4: 32'h10});
    step(1'b0, 1'b1, 32'h00400213, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) begin
      chk("hold_noreq", {31'b0, imem_req}, 32'd0);
      chk("stall_InstrD", InstrD, 32'h00308193);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    idle();
    chk("after_hold_addr", imem_addr, 32'h10);

    // Redirect while response pending; low target bits ignored
    grant(32'h10);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h103);
    chk("redir_ValidD", {31'b0, ValidD}, 32'd0);
    chk("redir_InstrD", InstrD, 32'h13);
    chk("redir_PCD", PCD, 32'h0);
    chk("kill_noreq", {31'b0, imem_req}, 32'd0);
    step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    grant(32'h100); resp(32'h00100293, 32'h100);

    // Redirect in the same cycle as grant
    addr_q.push_back(32'h104);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h40);
    idle();
    step(1'b0, 1'b1, 32'h0BADBAD0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("gnt_redir_addr", imem_addr, 32'h40);
    grant(32'h40); resp(32'h00200313, 32'h40);

    // FlushD coincident with response
    grant(32'h44);
    exp_q.push_back('{instr: 32'h00500393, pc: 32'h44, pc4: 32'h48});
    step(1'b0, 1'b1, 32'h00500393, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("flush_ValidD", {31'b0, ValidD}, 32'd0);
    chk("flush_InstrD", InstrD, 32'h13);
    chk("flush_noreq", {31'b0, imem_req}, 32'd0);
    idle();
    chk("flush_pcf", imem_addr, 32'h48);

    // Redirect discards the hold buffer
    grant(32'h48);
    step(1'b0, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h200);
    chk("holdredir_ValidD", {31'b0, ValidD}, 32'd0);
    chk("holdredir_addr", imem_addr, 32'h200);
    grant(32'h200); resp(32'h00600413, 32'h200);

    // Reset mid-transaction; stray rvalid afterwards is ignored
    grant(32'h204);
    reset = 1'b1;
    idle();
    chk("midrst_ValidD", {31'b0, ValidD}, 32'd0);
    chk("midrst_req", {31'b0, imem_req}, 32'd0);
    reset = 1'b0;
    step(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stray_InstrD", InstrD, 32'h13);
    chk("stray_addr", imem_addr, 32'h0);
    grant(32'h0); resp(32'h00700493, 32'h0);

    // PCPlus4D wraps at the top of the address space
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    grant(32'hFFFFFFFC); resp(32'h00800513, 32'hFFFFFFFC);

    idle(); idle();
    chk("ifid_q_empty", exp_q.size(), 32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
